// File: rtl/tankwar_pkg.sv
// tankwar_pkg: shared object state-word layout, enums and span record for the tank game.
package tankwar_pkg;
    localparam int ACT_BIT     = 31;
    localparam int DIR_LSB     = 29;
    localparam int DIR_W       = 2;
    localparam int X_LSB       = 19;
    localparam int Y_LSB       = 9;
    localparam int COORD_W     = 10;
    localparam int TANK_SIZE   = 32;
    localparam int BULLET_SIZE = 8;
    localparam int OFS_W       = $clog2(TANK_SIZE);

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
    typedef enum logic [2:0] {OBJ_NONE, OBJ_TANK, OBJ_OPPO, OBJ_PBULLET, OBJ_EBULLET} obj_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [OFS_W-1:0]   row;
        dir_e               dir;
        obj_e               obj;
        logic               valid;
    } span_t;

    function automatic logic [COORD_W-1:0] x_of(input logic [31:0] w);
        return w[X_LSB +: COORD_W];
    endfunction

    function automatic logic [COORD_W-1:0] y_of(input logic [31:0] w);
        return w[Y_LSB +: COORD_W];
    endfunction
endpackage

// File: rtl/span_hit_cmp.sv
// span_hit_cmp: horizontal range test of one span slot against the current pixel column.
module span_hit_cmp #(
    parameter int TANK_SIZE   = 32,
    parameter int BULLET_SIZE = 8,
    parameter int COL_W       = $clog2(TANK_SIZE)
) (
    input  logic [9:0]       x,
    input  logic [9:0]       pixel_x,
    input  logic             valid,
    input  logic             is_tank,
    output logic             hit,
    output logic [COL_W-1:0] col
);
    logic [10:0] lo;
    logic [10:0] px;
    always_comb begin
        lo  = {1'b0, x};
        px  = {1'b0, pixel_x};
        hit = valid && lo <= px && px < lo + (is_tank ? 11'(TANK_SIZE) : 11'(BULLET_SIZE));
        col = hit ? COL_W'(pixel_x - x) : '0;
    end
endmodule

// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: per-line span list builder (double-buffered) and per-pixel object resolver.
module sprite_line_renderer #(
    parameter int MAX_BULLETS = 8,
    parameter int SPAN_SLOTS  = 8,
    parameter int TANK_SIZE   = tankwar_pkg::TANK_SIZE,
    parameter int BULLET_SIZE = tankwar_pkg::BULLET_SIZE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          line_start,
    input  logic [9:0]                    line_y,
    input  logic                          video_on,
    input  logic [9:0]                    pixel_x,
    input  logic [31:0]                   tank_ram_data,
    input  logic [31:0]                   oppo_ram_data,
    input  logic [2*MAX_BULLETS-1:0][31:0] bullet_ram_data,
    output logic [2:0]                    pixel_obj,
    output logic [1:0]                    pixel_dir,
    output logic [4:0]                    pixel_col,
    output logic [4:0]                    pixel_row,
    output logic                          scan_busy,
    output logic                          line_overflow
);
    import tankwar_pkg::*;

    localparam int N_OBJ = 2 + 2 * MAX_BULLETS;
    localparam int IW    = $clog2(N_OBJ);
    localparam int BW    = $clog2(2 * MAX_BULLETS);
    localparam int CW    = $clog2(SPAN_SLOTS + 1);
    localparam int SW    = $clog2(SPAN_SLOTS);

    typedef enum logic {IDLE, SCAN} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [9:0]      ly_q, ly_d;
    logic            ovf_q, ovf_d;
    logic            line_overflow_q, line_overflow_d;
    logic            disp_q, disp_d;
    span_t           bank_q [2][SPAN_SLOTS];
    span_t           bank_d [2][SPAN_SLOTS];
    logic [2:0]      pixel_obj_q, pixel_obj_d;
    logic [1:0]      pixel_dir_q, pixel_dir_d;
    logic [4:0]      pixel_col_q, pixel_col_d;
    logic [4:0]      pixel_row_q, pixel_row_d;

    logic [31:0]     word;
    logic [BW-1:0]   bidx;
    obj_e            obj;
    logic [10:0]     oy, ly, osize;
    logic            hit;
    logic            unused_reserved;

    always_comb begin
        bidx  = BW'(idx_q - IW'(2));
        word  = idx_q == IW'(0) ? tank_ram_data : idx_q == IW'(1) ? oppo_ram_data : bullet_ram_data[bidx];
        obj   = idx_q == IW'(0) ? OBJ_TANK : idx_q == IW'(1) ? OBJ_OPPO :
                bidx < BW'(MAX_BULLETS) ? OBJ_PBULLET : OBJ_EBULLET;
        osize = idx_q < IW'(2) ? 11'(TANK_SIZE) : 11'(BULLET_SIZE);
        oy    = {1'b0, y_of(word)};
        ly    = {1'b0, ly_q};
        hit   = word[ACT_BIT] && oy <= ly && ly < oy + osize;
        unused_reserved = ^word[Y_LSB-1:0];
        state_d         = state_q;
        idx_d           = idx_q;
        cnt_d           = cnt_q;
        ly_d            = ly_q;
        ovf_d           = ovf_q;
        line_overflow_d = line_overflow_q;
        disp_d          = disp_q;
        bank_d          = bank_q;
        // A new line_start always wins, even mid-scan: the partial list is shown as-is.
        if (line_start) begin
            state_d = SCAN;
            disp_d  = ~disp_q;
            idx_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            ly_d    = line_y;
            for (int s = 0; s < SPAN_SLOTS; s++) bank_d[disp_q][s].valid = 1'b0;
        end else if (state_q == SCAN) begin
            if (hit && cnt_q < CW'(SPAN_SLOTS)) begin
                bank_d[~disp_q][SW'(cnt_q)] = '{x: x_of(word), row: OFS_W'(ly_q - y_of(word)),
                                               dir: dir_e'(word[DIR_LSB +: DIR_W]), obj: obj, valid: 1'b1};
                cnt_d = cnt_q + CW'(1);
            end
            ovf_d = ovf_q | (hit && cnt_q == CW'(SPAN_SLOTS));
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(N_OBJ - 1)) begin
                state_d         = IDLE;
                line_overflow_d = ovf_d;
            end
        end
    end

    span_t                   disp_span [SPAN_SLOTS];
    logic [SPAN_SLOTS-1:0]   hits;
    logic [OFS_W-1:0]        cols [SPAN_SLOTS];
    logic [SW-1:0]           sel;
    logic                    pix_hit;

    always_comb begin
        for (int s = 0; s < SPAN_SLOTS; s++) disp_span[s] = bank_q[disp_q][s];
    end

    for (genvar s = 0; s < SPAN_SLOTS; s++) begin : g_cmp
        span_hit_cmp #(.TANK_SIZE(TANK_SIZE), .BULLET_SIZE(BULLET_SIZE), .COL_W(OFS_W)) u_cmp (
            .x       (disp_span[s].x),
            .pixel_x (pixel_x),
            .valid   (disp_span[s].valid),
            .is_tank (disp_span[s].obj == OBJ_TANK || disp_span[s].obj == OBJ_OPPO),
            .hit     (hits[s]),
            .col     (cols[s])
        );
    end

    // Slots fill in scan order, so the lowest hitting slot puts tanks above bullets.
    always_comb begin
        sel = '0;
        for (int i = SPAN_SLOTS - 1; i >= 0; i--) sel = hits[i] ? SW'(i) : sel;
        pix_hit     = video_on && |hits;
        pixel_obj_d = pix_hit ? disp_span[sel].obj : OBJ_NONE;
        pixel_dir_d = pix_hit ? disp_span[sel].dir : 2'd0;
        pixel_col_d = pix_hit ? 5'(cols[sel]) : 5'd0;
        pixel_row_d = pix_hit ? 5'(disp_span[sel].row) : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            cnt_q           <= '0;
            ly_q            <= '0;
            ovf_q           <= 1'b0;
            line_overflow_q <= 1'b0;
            disp_q          <= 1'b0;
            pixel_obj_q     <= '0;
            pixel_dir_q     <= '0;
            pixel_col_q     <= '0;
            pixel_row_q     <= '0;
            for (int b = 0; b < 2; b++)
                for (int s = 0; s < SPAN_SLOTS; s++) bank_q[b][s] <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            ly_q            <= ly_d;
            ovf_q           <= ovf_d;
            line_overflow_q <= line_overflow_d;
            disp_q          <= disp_d;
            pixel_obj_q     <= pixel_obj_d;
            pixel_dir_q     <= pixel_dir_d;
            pixel_col_q     <= pixel_col_d;
            pixel_row_q     <= pixel_row_d;
            bank_q          <= bank_d;
        end
    end

    assign pixel_obj     = pixel_obj_q;
    assign pixel_dir     = pixel_dir_q;
    assign pixel_col     = pixel_col_q;
    assign pixel_row     = pixel_row_q;
    assign scan_busy     = state_q == SCAN;
    assign line_overflow = line_overflow_q;
endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb_sprite_line_renderer: directed scoreboard bench for the scanline span builder and pixel resolver.
module tb_sprite_line_renderer;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              line_start = 1'b0;
    logic [9:0]        line_y = '0;
    logic              video_on = 1'b0;
    logic [9:0]        pixel_x = '0;
    logic [31:0]       tank_w = '0;
    logic [31:0]       oppo_w = '0;
    logic [15:0][31:0] bul = '0;
    logic [2:0]        pixel_obj;
    logic [1:0]        pixel_dir;
    logic [4:0]        pixel_col;
    logic [4:0]        pixel_row;
    logic              scan_busy;
    logic              line_overflow;

    sprite_line_renderer dut (
        .clk             (clk),
        .reset           (reset),
        .line_start      (line_start),
        .line_y          (line_y),
        .video_on        (video_on),
        .pixel_x         (pixel_x),
        .tank_ram_data   (tank_w),
        .oppo_ram_data   (oppo_w),
        .bullet_ram_data (bul),
        .pixel_obj       (pixel_obj),
        .pixel_dir       (pixel_dir),
        .pixel_col       (pixel_col),
        .pixel_row       (pixel_row),
        .scan_busy       (scan_busy),
        .line_overflow   (line_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    obj;
        int    dir;
        int    col;
        int    row;
        string name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic req = 1'b0;
    logic chk_v = 1'b0;

    always @(posedge clk) chk_v <= req;

    always @(negedge clk) begin
        if (chk_v) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: output presented with no expectation queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (pixel_obj != e.obj || pixel_dir != e.dir || pixel_col != e.col || pixel_row != e.row) begin
                    bad++;
                    $display("FAIL %s: got obj=%0d dir=%0d col=%0d row=%0d, want obj=%0d dir=%0d col=%0d row=%0d",
                             e.name, pixel_obj, pixel_dir, pixel_col, pixel_row, e.obj, e.dir, e.col, e.row);
                end
            end
        end
    end

    function automatic logic [31:0] word(input bit act, input int dir, input int x, input int y);
        return {act, 2'(dir), 10'(x), 10'(y), 9'h1A5};
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", n, act, exp);
        end
    endtask

    task automatic pix(input string n, input int x, input bit vo, input int o, input int d, input int c, input int r);
        pixel_x  = 10'(x);
        video_on = vo;
        sb.push_back('{obj: o, dir: d, col: c, row: r, name: n});
        req = 1'b1;
        @(negedge clk);
        req      = 1'b0;
        video_on = 1'b0;
    endtask

    task automatic do_line(input int y);
        int n;
        line_y     = 10'(y);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        n = 0;
        while (scan_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("scan_len", n, 18);
    endtask

    task automatic render(input int y);
        do_line(y);
        do_line(y);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_obj", pixel_obj, 0);
        chk("rst_busy", scan_busy, 0);
        chk("rst_ovf", line_overflow, 0);
        chk("rst_colrow", {pixel_dir, pixel_col, pixel_row}, 0);
        pix("rst_empty", 40, 1, 0, 0, 0, 0);

        tank_w = word(1, 3, 32, 32);
        render(40);
        pix("t1_hit", 40, 1, 1, 3, 8, 8);
        pix("t1_right_out", 64, 1, 0, 0, 0, 0);
        pix("t1_left_out", 31, 1, 0, 0, 0, 0);
        pix("t1_right_edge", 63, 1, 1, 3, 31, 8);

        render(63);
        pix("t2_last_row", 32, 1, 1, 3, 0, 31);
        render(64);
        pix("t2_below", 40, 1, 0, 0, 0, 0);
        render(31);
        pix("t2_above", 40, 1, 0, 0, 0, 0);
        tank_w = word(1, 3, 1000, 32);
        render(40);
        pix("t2_nowrap", 1023, 1, 1, 3, 23, 8);
        pix("t2_x_left", 1000, 1, 1, 3, 0, 8);
        pix("t2_x_before", 999, 1, 0, 0, 0, 0);

        tank_w  = word(1, 0, 100, 100);
        bul[8]  = word(1, 2, 104, 104);
        render(106);
        pix("t3_prio", 105, 1, 1, 0, 5, 6);
        pix("t3_prio2", 110, 1, 1, 0, 10, 6);
        tank_w = word(1, 0, 300, 100);
        render(106);
        pix("t3_ebullet", 105, 1, 4, 2, 1, 2);
        pix("t3_eb_after", 112, 1, 0, 0, 0, 0);
        pix("t3_eb_before", 103, 1, 0, 0, 0, 0);

        tank_w = word(1, 0, 0, 200);
        oppo_w = word(1, 1, 40, 200);
        bul    = '0;
        for (int i = 0; i < 8; i++) bul[i] = word(1, 1, 100 + 16 * i, 200);
        render(202);
        chk("t4_ovf_set", line_overflow, 1);
        pix("t4_tank", 0, 1, 1, 0, 0, 2);
        pix("t4_oppo", 45, 1, 2, 1, 5, 2);
        pix("t4_b5", 180, 1, 3, 1, 0, 2);
        pix("t4_b5_col", 183, 1, 3, 1, 3, 2);
        pix("t4_b6_drop", 196, 1, 0, 0, 0, 0);
        pix("t4_b7_drop", 212, 1, 0, 0, 0, 0);

        line_y     = 10'd202;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_ovf_held", line_overflow, 1);
        do_line(40);
        chk("t5_ovf_clear", line_overflow, 0);
        pix("t5_part_tank", 0, 1, 1, 0, 0, 2);
        pix("t5_part_oppo", 45, 1, 2, 1, 5, 2);
        pix("t5_part_b1", 116, 1, 3, 1, 0, 2);
        pix("t5_part_b2_absent", 132, 1, 0, 0, 0, 0);
        do_line(40);
        pix("t5_no_stale_tank", 0, 1, 0, 0, 0, 0);
        pix("t5_no_stale_b1", 116, 1, 0, 0, 0, 0);

        tank_w = word(0, 3, 32, 32);
        oppo_w = word(0, 1, 100, 32);
        for (int i = 0; i < 16; i++) bul[i] = word(0, 2, 200 + 16 * i, 36);
        render(40);
        pix("t6_inact_tank", 40, 1, 0, 0, 0, 0);
        pix("t6_inact_oppo", 100, 1, 0, 0, 0, 0);
        pix("t6_inact_bul", 202, 1, 0, 0, 0, 0);
        tank_w = word(1, 3, 32, 32);
        render(40);
        pix("t6_video_off", 40, 0, 0, 0, 0, 0);
        pix("t6_video_on", 40, 1, 1, 3, 8, 8);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
